i2c_slave: RTL and testbench

I2C target (slave) endpoint with a fixed 7-bit address. It oversamples SCL/SDA on the system clock, detects START/STOP and repeated START, and ACKs its own address. It receives write bytes for the user logic and transmits read bytes supplied by it. It sits opposite the team's I2C master on the same two-wire bus and works at any SCL rate the system clock can oversample.

---
 rtl/i2c_slave.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_slave.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target endpoint with a fixed 7-bit address. SCL/SDA are oversampled on clk;
// write bytes go to the user logic, read bytes come from it, SCL is never stretched.
module i2c_slave #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned I2C_FREQ   = 100_000,
    parameter logic [6:0]  SLAVE_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic       msb_lsb,
    output logic [7:0] byte_received,
    output logic       rx_valid,
    input  logic [7:0] byte_2_send,
    output logic       tx_req,
    output logic       busy,
    output logic       rw
);
    generate
        if (CLK_FREQ / I2C_FREQ < 20) begin : g_ratio_check
            $fatal(1, "i2c_slave: CLK_FREQ / I2C_FREQ must be at least 20");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE
    } state_e;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_hist_q, sda_hist_q;
    logic       scl_rise_q, scl_fall_q, start_q, stop_q;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_low_q, sda_low_d;
    logic [7:0] byte_received_q, byte_received_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic [7:0] rx_shift;
    logic       load_tx;

    // Bit idx of a data byte in wire order, honouring the configured bit order.
    function automatic logic tx_bit(input logic [7:0] data, input logic [2:0] idx,
                                    input logic msb_first);
        return msb_first ? data[3'd7 - idx] : data[idx];
    endfunction

    // Events are registered so SDA drive changes land one clk after the SCL fall event.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
            scl_rise_q <= scl_sync_q[1] & ~scl_hist_q;
            scl_fall_q <= ~scl_sync_q[1] & scl_hist_q;
            start_q    <= scl_sync_q[1] & scl_hist_q & ~sda_sync_q[1] & sda_hist_q;
            stop_q     <= scl_sync_q[1] & scl_hist_q & sda_sync_q[1] & ~sda_hist_q;
        end
    end

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this block infers a latch.
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        sda_low_d       = sda_low_q;
        byte_received_d = byte_received_q;
        rx_valid_d      = 1'b0;
        tx_req_d        = 1'b0;
        busy_d          = busy_q;
        rw_d            = rw_q;
        load_tx         = 1'b0;
        rx_shift        = msb_lsb ? {shift_q[6:0], sda_hist_q} : {sda_hist_q, shift_q[7:1]};

        if (start_q) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_q) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise_q) begin
                    shift_d   = {shift_q[6:0], sda_hist_q};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (shift_d[7:1] == SLAVE_ADDR) begin
                            state_d = ADDR_ACK;
                            rw_d    = shift_d[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                // First fall starts the ACK low, the second one ends it.
                ADDR_ACK: if (scl_fall_q) begin
                    if (!sda_low_q) begin
                        sda_low_d = 1'b1;
                    end else if (!rw_q) begin
                        sda_low_d = 1'b0;
                        state_d   = RX;
                    end else begin
                        load_tx = 1'b1;
                    end
                end
                RX: if (scl_rise_q) begin
                    shift_d   = rx_shift;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_received_d = rx_shift;
                        rx_valid_d      = 1'b1;
                        state_d         = RX_ACK;
                    end
                end
                RX_ACK: if (scl_fall_q) begin
                    if (!sda_low_q) begin
                        sda_low_d = 1'b1;
                    end else begin
                        sda_low_d = 1'b0;
                        state_d   = RX;
                    end
                end
                TX: if (scl_fall_q) begin
                    if (bit_cnt_q == 3'd7) begin
                        sda_low_d = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = TX_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        sda_low_d = ~tx_bit(shift_q, bit_cnt_q + 3'd1, msb_lsb);
                    end
                end
                TX_ACK: begin
                    if (scl_rise_q && sda_hist_q) begin
                        state_d = IGNORE;
                        busy_d  = 1'b0;
                    end else if (scl_fall_q) begin
                        load_tx = 1'b1;
                    end
                end
                IDLE, IGNORE: sda_low_d = 1'b0;
                default: begin
                    state_d   = IDLE;
                    sda_low_d = 1'b0;
                end
            endcase

            if (load_tx) begin
                state_d   = TX;
                shift_d   = byte_2_send;
                tx_req_d  = 1'b1;
                bit_cnt_d = 3'd0;
                sda_low_d = ~tx_bit(byte_2_send, 3'd0, msb_lsb);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            bit_cnt_q       <= 3'd0;
            shift_q         <= 8'h00;
            sda_low_q       <= 1'b0;
            byte_received_q <= 8'h00;
            rx_valid_q      <= 1'b0;
            tx_req_q        <= 1'b0;
            busy_q          <= 1'b0;
            rw_q            <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            sda_low_q       <= sda_low_d;
            byte_received_q <= byte_received_d;
            rx_valid_q      <= rx_valid_d;
            tx_req_q        <= tx_req_d;
            busy_q          <= busy_d;
            rw_q            <= rw_d;
        end
    end

    assign sda           = sda_low_q ? 1'b0 : 1'bz;
    assign byte_received = byte_received_q;
    assign rx_valid      = rx_valid_q;
    assign tx_req        = tx_req_q;
    assign busy          = busy_q;
    assign rw            = rw_q;
endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged bus master drives transactions while a monitor
// pops expected rx bytes / tx_req pulses from a scoreboard when the DUT presents them.
module tb_i2c_slave;
    localparam int Q = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic       msb_lsb = 1'b1;
    logic [7:0] byte_2_send = 8'h00;
    wire        sda;
    logic [7:0] byte_received;
    logic       rx_valid, tx_req, busy, rw;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(
        .CLK_FREQ  (100_000_000),
        .I2C_FREQ  (2_500_000),
        .SLAVE_ADDR(7'h42)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .scl          (scl),
        .sda          (sda),
        .msb_lsb      (msb_lsb),
        .byte_received(byte_received),
        .rx_valid     (rx_valid),
        .byte_2_send  (byte_2_send),
        .tx_req       (tx_req),
        .busy         (busy),
        .rw           (rw)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_rx_q[$];
    int         exp_txreq = 0;
    int         dut_low_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin : monitor
        logic [7:0] exp_b;
        forever begin
            @(posedge clk);
            #1;
            if (sda === 1'b0 && !m_sda_low) dut_low_cycles++;
            if (rx_valid) begin
                if (exp_rx_q.size() == 0) begin
                    check("unexpected_rx_valid", {24'd0, byte_received}, 32'hFFFF_FFFF);
                end else begin
                    exp_b = exp_rx_q.pop_front();
                    check("rx_byte", {24'd0, byte_received}, {24'd0, exp_b});
                end
            end
            if (tx_req) begin
                check("tx_req_expected", {31'd0, exp_txreq > 0}, 32'd1);
                if (exp_txreq > 0) exp_txreq--;
            end
        end
    end

    initial begin : watchdog
        #600_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1;       wait_q();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b0;       wait_q();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b1;       wait_q();
        m_sda_low = 1'b0; wait_q();
        wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; wait_q();
        scl = 1'b1;     wait_q(); wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1;       wait_q();
        b = sda;          wait_q();
        scl = 1'b0;       wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, input logic msb_first, output logic ack_bit);
        for (int i = 0; i < 8; i++) write_bit(msb_first ? b[7 - i] : b[i]);
        read_bit(ack_bit);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        logic bit_v;
        for (int i = 0; i < 8; i++) begin
            read_bit(bit_v);
            b[7 - i] = bit_v;
        end
        write_bit(nack);
    endtask

    initial begin : stimulus
        logic       ack;
        logic [7:0] rd;
        int         low_before;

        // Reset
        repeat (5) @(negedge clk);
        check("rst_byte_received", {24'd0, byte_received}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rw", {31'd0, rw}, 32'd0);
        check("rst_sda_released", {31'd0, sda}, 32'd1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Write 0xA5 to 0x42, MSB first
        msb_lsb = 1'b1;
        i2c_start();
        write_byte(8'h84, 1'b1, ack);
        check("wr_addr_ack", {31'd0, ack}, 32'd0);
        check("wr_busy_high", {31'd0, busy}, 32'd1);
        check("wr_rw", {31'd0, rw}, 32'd0);
        exp_rx_q.push_back(8'hA5);
        write_byte(8'hA5, 1'b1, ack);
        check("wr_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
        check("wr_rx_drained", exp_rx_q.size(), 32'd0);

        // Read 0x3C (ACK) then 0xC3 (NACK)
        byte_2_send = 8'h3C;
        exp_txreq++;
        i2c_start();
        write_byte(8'h85, 1'b1, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd0);
        byte_2_send = 8'hC3;
        exp_txreq++;
        read_byte(rd, 1'b0);
        check("rd_byte0", {24'd0, rd}, 32'h3C);
        read_byte(rd, 1'b1);
        check("rd_byte1", {24'd0, rd}, 32'hC3);
        check("rd_busy_after_nack", {31'd0, busy}, 32'd0);
        check("rd_rw", {31'd0, rw}, 32'd1);
        check("rd_sda_released", {31'd0, sda}, 32'd1);
        i2c_stop();
        check("rd_txreq_drained", exp_txreq, 32'd0);

        // Address mismatch: nothing driven, nothing reported
        low_before = dut_low_cycles;
        i2c_start();
        write_byte(8'hA0, 1'b1, ack);
        check("mm_addr_nack", {31'd0, ack}, 32'd1);
        write_byte(8'h55, 1'b1, ack);
        check("mm_data_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("mm_sda_never_driven", dut_low_cycles - low_before, 32'd0);
        check("mm_busy", {31'd0, busy}, 32'd0);

        // LSB-first write: wire bits 1,0,0,0,0,0,0,0
        msb_lsb = 1'b0;
        i2c_start();
        write_byte(8'h84, 1'b1, ack);
        check("lsb_addr_ack", {31'd0, ack}, 32'd0);
        exp_rx_q.push_back(8'h01);
        write_byte(8'h01, 1'b0, ack);
        check("lsb_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("lsb_byte_received", {24'd0, byte_received}, 32'h01);

        // Repeated START after 4 data bits, then read
        msb_lsb = 1'b1;
        i2c_start();
        write_byte(8'h84, 1'b1, ack);
        check("rs_addr_ack", {31'd0, ack}, 32'd0);
        write_bit(1'b1); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        byte_2_send = 8'h5A;
        exp_txreq++;
        i2c_start();
        write_byte(8'h85, 1'b1, ack);
        check("rs_read_addr_ack", {31'd0, ack}, 32'd0);
        check("rs_rw", {31'd0, rw}, 32'd1);
        check("rs_busy", {31'd0, busy}, 32'd1);
        read_byte(rd, 1'b1);
        check("rs_read_byte", {24'd0, rd}, 32'h5A);
        i2c_stop();
        check("rs_byte_unchanged", {24'd0, byte_received}, 32'h01);
        check("rs_rx_drained", exp_rx_q.size(), 32'd0);
        check("rs_txreq_drained", exp_txreq, 32'd0);

        // Reset while the DUT holds the address ACK low
        i2c_start();
        for (int i = 0; i < 8; i++) write_bit(i == 0 || i == 5);
        m_sda_low = 1'b0;
        @(negedge clk);
        check("rr_ack_driven", {31'd0, sda}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rr_sda_released", {31'd0, sda}, 32'd1);
        repeat (4) @(negedge clk);
        check("rr_busy", {31'd0, busy}, 32'd0);
        check("rr_rw", {31'd0, rw}, 32'd0);
        check("rr_byte_received", {24'd0, byte_received}, 32'h00);
        check("rr_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rr_tx_req", {31'd0, tx_req}, 32'd0);
        rst = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        check("rr_idle_busy", {31'd0, busy}, 32'd0);
        check("end_rx_drained", exp_rx_q.size(), 32'd0);
        check("end_txreq_drained", exp_txreq, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
